// File: rtl/cpu_inta_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_inta_sequencer
//
// CPU-side initiator of the 8259 interrupt-acknowledge handshake. Samples the
// PIC INT line through a two-flop synchronizer, issues the 8086-style
// two-pulse INTA_n sequence, captures the vector byte on the edge that ends
// the second pulse, and then blocks further acknowledges until the CPU
// signals return-from-interrupt with iret.
//
// Parameters:
//   PULSE_CYCLES  clk cycles INTA_n is held low per pulse (>=1)
//   GAP_CYCLES    clk cycles INTA_n is held high between the pulses (>=1)
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   INT           interrupt request from PIC (asynchronous, active high)
//   int_enable    CPU interrupt-enable flag
//   iret          one-cycle pulse, CPU finished the ISR
//   data_bus      PIC data bus, valid during the second INTA pulse
//   INTA_n        interrupt acknowledge to PIC, active low, registered
//   vector        captured interrupt vector, holds until next capture
//   vector_valid  one-cycle pulse when vector updates
//   busy          high from leaving IDLE until re-armed, registered
//   spurious      (only with INTA_SPURIOUS_DETECT_EN) INT was seen low
//                 during GAP or P2 of the last sequence
//
// Optional feature macro: INTA_SPURIOUS_DETECT_EN
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | armed, waiting for synchronized INT with interrupts enabled
// P1      | first INTA_n low pulse
// GAP     | INTA_n high between the two pulses
// P2      | second INTA_n low pulse, vector captured on its last edge
// DONE    | vector_valid high for one cycle
// SERVICE | ISR running, waiting for iret to re-arm
// ---------------------------------------------------------------------------
module cpu_inta_sequencer #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT,
    input  logic       int_enable,
    input  logic       iret,
    input  logic [7:0] data_bus,
    output logic       INTA_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       busy
`ifdef INTA_SPURIOUS_DETECT_EN
    ,
    output logic       spurious
`endif
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // Counter holds "cycles remaining minus one" so the phase ends when it reads zero.
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_GAP,
        S_P2,
        S_DONE,
        S_SERVICE
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             int_meta;
    logic             int_s;
    logic             cnt_zero;
    logic             capture;
    logic             enter_p1;

    assign cnt_zero = (cnt == '0);
    assign capture  = (state == S_P2) && cnt_zero;
    assign enter_p1 = (state == S_IDLE) && (next_state == S_P1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            int_meta <= 1'b0;
            int_s    <= 1'b0;
        end else begin
            int_meta <= INT;
            int_s    <= int_meta;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (int_s && int_enable) begin
                    next_state = S_P1;
                    cnt_next   = PULSE_LOAD;
                end
            end
            S_P1: begin
                if (cnt_zero) begin
                    next_state = S_GAP;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            S_GAP: begin
                if (cnt_zero) begin
                    next_state = S_P2;
                    cnt_next   = PULSE_LOAD;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            S_P2: begin
                if (cnt_zero) begin
                    next_state = S_DONE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - CNT_ONE;
                end
            end
            S_DONE: begin
                next_state = S_SERVICE;
                cnt_next   = '0;
            end
            S_SERVICE: begin
                if (iret) begin
                    next_state = S_IDLE;
                    cnt_next   = '0;
                end
            end
            default: begin
                next_state = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // INTA_n and busy are registered from next_state so they change exactly
    // on the state-entry edge and never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            cnt          <= '0;
            INTA_n       <= 1'b1;
            busy         <= 1'b0;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
        end else begin
            state        <= next_state;
            cnt          <= cnt_next;
            INTA_n       <= !((next_state == S_P1) || (next_state == S_P2));
            busy         <= (next_state != S_IDLE);
            vector_valid <= capture;
            if (capture) begin
                vector <= data_bus;
            end
        end
    end

`ifdef INTA_SPURIOUS_DETECT_EN
    // spur_seen remembers a low int_s in any earlier GAP/P2 cycle; the final
    // P2 cycle is folded in directly at capture time.
    logic spur_seen;
    logic in_gap_or_p2;

    assign in_gap_or_p2 = (state == S_GAP) || (state == S_P2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spur_seen <= 1'b0;
            spurious  <= 1'b0;
        end else begin
            if (enter_p1) begin
                spur_seen <= 1'b0;
                spurious  <= 1'b0;
            end else begin
                if (in_gap_or_p2 && !int_s) begin
                    spur_seen <= 1'b1;
                end
                if (capture) begin
                    spurious <= spur_seen || !int_s;
                end
            end
        end
    end
`else
    logic unused_enter_p1;
    assign unused_enter_p1 = enter_p1;
`endif

endmodule
